wr_page_packer: RTL and testbench

WR_PAGE_PACKER -- requirements
Module: wr_page_packer

---
 rtl/wr_page_packer_if.sv | 25 ++
 rtl/wr_page_packer.sv | 209 ++++++++++++++++++++
 tb/tb_wr_page_packer.sv | 297 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wr_page_packer_if.sv
// Ingress word stream into the page packer: valid/ready handshake with
// packet delimiters and a 16-bit data word.
interface wr_page_packer_if;
  logic        in_vld;
  logic        in_sop;
  logic        in_eop;
  logic [15:0] in_data;
  logic        in_rdy;

  modport master (
    output in_vld,
    output in_sop,
    output in_eop,
    output in_data,
    input  in_rdy
  );

  modport slave (
    input  in_vld,
    input  in_sop,
    input  in_eop,
    input  in_data,
    output in_rdy
  );
endinterface

// File: rtl/wr_page_packer.sv
// Write-side page packer: checks each packet header against free SRAM pages,
// stages accepted packets through a ping-pong pair of 8-word page buffers and
// streams each page to sram_ctrl as a contiguous burst of write strobes.
module wr_page_packer (
  input  logic                   sys_clk,
  input  logic                   sys_rst_n,
  wr_page_packer_if.slave        ingress,
  input  logic [11:0]            cnt_em,
  output logic                   en_a,
  output logic [15:0]            data_ina,
  output logic [3:0]             port_ina,
  output logic                   wr_eop,
  output logic [15:0]            pkt_cnt,
  output logic [15:0]            drop_cnt,
  output logic                   len_err
);

  typedef enum logic [2:0] {IDLE, CHK, FILL, DROP, DRAIN} state_t;

  state_t      state;
  logic        live;       // low only until the first clock after reset release
  logic [15:0] hdr;
  logic [8:0]  len;
  logic [3:0]  port;
  logic        hdr_eop;
  logic        hdr_pend;   // header accepted but its page buffer is still draining
  logic [8:0]  wcnt;       // words of the current packet already stored
  logic        wr_sel;
  logic [2:0]  wr_idx;

  logic [15:0] mem [2][8];
  logic [1:0]  buf_full;
  logic [1:0]  buf_last;
  logic [3:0]  buf_cnt  [2];
  logic [3:0]  buf_port [2];

  logic        rd_sel;
  logic [2:0]  rd_idx;
  logic        gap;        // forces one idle write cycle after wr_eop

  logic [6:0]  pages;
  logic        drop_hdr;
  logic        acc;
  logic        len_hit;
  logic        push;
  logic [15:0] push_data;
  logic        push_eop;
  logic        push_final;
  logic        hand;
  logic        rd_fire;
  logic        rd_end;

  // Pages needed is ceil(len/8); cnt_em compared unsigned against it.
  assign pages    = {1'b0, len[8:3]} + {6'd0, |len[2:0]};
  assign drop_hdr = (len == '0) || ({5'd0, pages} > cnt_em);
  assign len_hit  = (wcnt + 9'd1) == len;

  assign ingress.in_rdy = live && ((state == IDLE) || (state == DROP) || (state == DRAIN) ||
                                   ((state == FILL) && !hdr_pend && !buf_full[wr_sel]));
  assign acc = ingress.in_vld && ingress.in_rdy;

  // Select the word entering the fill buffer this cycle and detect page handoff.
  // The header is written in CHK when its buffer is free; otherwise it is held
  // and written from FILL once the drain side releases that buffer.
  always_comb begin
    push      = 1'b0;
    push_data = hdr;
    push_eop  = hdr_eop;
    case (state)
      CHK: begin
        if (!drop_hdr && !buf_full[wr_sel]) push = 1'b1;
      end
      FILL: begin
        if (hdr_pend) begin
          if (!buf_full[wr_sel]) push = 1'b1;
        end else if (acc) begin
          push      = 1'b1;
          push_data = ingress.in_data;
          push_eop  = ingress.in_eop;
        end
      end
      default: ;
    endcase
    push_final = push && (push_eop || len_hit);
    hand       = push && (push_final || (wr_idx == 3'd7));
  end

  // Ingress FSM: header capture, page check, fill bookkeeping and discard states.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state    <= IDLE;
      live     <= 1'b0;
      hdr      <= '0;
      len      <= '0;
      port     <= '0;
      hdr_eop  <= 1'b0;
      hdr_pend <= 1'b0;
      wcnt     <= '0;
      wr_sel   <= 1'b0;
      wr_idx   <= '0;
      drop_cnt <= '0;
      len_err  <= 1'b0;
    end else begin
      live    <= 1'b1;
      len_err <= 1'b0;
      if (push) begin
        wcnt     <= wcnt + 9'd1;
        hdr_pend <= 1'b0;
        wr_idx   <= hand ? '0 : wr_idx + 3'd1;
        if (hand) wr_sel <= ~wr_sel;
      end
      case (state)
        IDLE: begin
          if (acc && ingress.in_sop) begin
            hdr     <= ingress.in_data;
            len     <= ingress.in_data[15:7];
            port    <= ingress.in_data[3:0];
            hdr_eop <= ingress.in_eop;
            wcnt    <= '0;
            state   <= CHK;
          end
        end
        CHK: begin
          if (drop_hdr) begin
            drop_cnt <= drop_cnt + 16'd1;
            state    <= hdr_eop ? IDLE : DROP;
          end else if (!push) begin
            hdr_pend <= 1'b1;
            state    <= FILL;
          end else if (!push_final) begin
            state <= FILL;
          end
        end
        FILL: ;
        DROP, DRAIN: begin
          if (acc && ingress.in_eop) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (push_final) begin
        len_err <= push_eop != len_hit;
        state   <= push_eop ? IDLE : DRAIN;
      end
    end
  end

  // Page buffer storage; validity is tracked separately so no reset is needed.
  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_sel][wr_idx] <= push_data;
  end

  // Buffer ownership flags: set by fill-side handoff, cleared when a page drains.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      buf_full <= '0;
      buf_last <= '0;
      for (int unsigned i = 0; i < 2; i++) begin
        buf_cnt[i]  <= '0;
        buf_port[i] <= '0;
      end
    end else begin
      if (hand) begin
        buf_full[wr_sel] <= 1'b1;
        buf_last[wr_sel] <= push_final;
        buf_cnt[wr_sel]  <= {1'b0, wr_idx} + 4'd1;
        buf_port[wr_sel] <= port;
      end
      if (rd_end) buf_full[rd_sel] <= 1'b0;
    end
  end

  assign rd_fire = !gap && buf_full[rd_sel];
  assign rd_end  = rd_fire && (({1'b0, rd_idx} + 4'd1) == buf_cnt[rd_sel]);

  // Drain side: one write per cycle from the oldest full buffer, rolling
  // straight into the next page unless the packet just ended.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      en_a     <= 1'b0;
      wr_eop   <= 1'b0;
      data_ina <= '0;
      port_ina <= '0;
      pkt_cnt  <= '0;
      rd_sel   <= 1'b0;
      rd_idx   <= '0;
      gap      <= 1'b0;
    end else begin
      en_a   <= rd_fire;
      wr_eop <= 1'b0;
      gap    <= 1'b0;
      if (rd_fire) begin
        data_ina <= mem[rd_sel][rd_idx];
        port_ina <= buf_port[rd_sel];
        if (rd_end) begin
          rd_sel <= ~rd_sel;
          rd_idx <= '0;
          if (buf_last[rd_sel]) begin
            wr_eop  <= 1'b1;
            pkt_cnt <= pkt_cnt + 16'd1;
            gap     <= 1'b1;
          end
        end else begin
          rd_idx <= rd_idx + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_wr_page_packer.sv
// Bench for wr_page_packer: table of packet vectors with a write-word
// scoreboard, plus hand sequences for back-to-back, overlap and reset cases.
module tb_wr_page_packer;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic [11:0] cnt_em;
  logic        en_a;
  logic [15:0] data_ina;
  logic [3:0]  port_ina;
  logic        wr_eop;
  logic [15:0] pkt_cnt;
  logic [15:0] drop_cnt;
  logic        len_err;

  wr_page_packer_if bus ();

  wr_page_packer dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .ingress  (bus),
    .cnt_em   (cnt_em),
    .en_a     (en_a),
    .data_ina (data_ina),
    .port_ina (port_ina),
    .wr_eop   (wr_eop),
    .pkt_cnt  (pkt_cnt),
    .drop_cnt (drop_cnt),
    .len_err  (len_err)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [15:0] data;
    logic [3:0]  port;
    logic        eop;
  } exp_t;

  typedef struct {
    logic [8:0]  len;
    logic [3:0]  port;
    int          nwords;
    logic [11:0] cnt;
    int          gap_at;
    int          gap_len;
    int          exp_emit;
    int          exp_drop;
    int          exp_err;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  int   runs[$];
  int   compared = 0;
  int   mismatched = 0;
  int   err_seen = 0;
  int   stalls = 0;
  int   run = 0;
  int   pkt_words = 0;
  bit   prev_en = 0;
  bit   prev_eop = 0;
  int   exp_pkt = 0;
  int   exp_drop = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Output monitor: scoreboard pop per write, idle-after-eop and page-boundary runs.
  always @(negedge sys_clk) begin
    if (!sys_rst_n) begin
      prev_en   = 0;
      prev_eop  = 0;
      run       = 0;
      pkt_words = 0;
    end else begin
      if (len_err) err_seen++;
      if (prev_eop) check("idle_after_eop", {31'd0, en_a}, 32'd0);
      if (wr_eop) check("eop_with_en_a", {31'd0, en_a}, 32'd1);
      if (en_a) begin
        run++;
        pkt_words++;
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL out_word: got write 0x%0h with empty scoreboard, expected no write", data_ina);
        end else begin
          mon_e = sb.pop_front();
          check("out_word", {11'd0, wr_eop, port_ina, data_ina}, {11'd0, mon_e.eop, mon_e.port, mon_e.data});
        end
        if (wr_eop) pkt_words = 0;
      end else if (prev_en) begin
        runs.push_back(run);
        check("run_ends_on_page", 32'(pkt_words % 8), 32'd0);
        run = 0;
      end
      prev_en  = en_a;
      prev_eop = en_a && wr_eop;
    end
  end

  task automatic send_word(input logic [15:0] d, input logic s, input logic e, input bit count_stall);
    bit r;
    bit done;
    done = 0;
    bus.in_vld  = 1'b1;
    bus.in_data = d;
    bus.in_sop  = s;
    bus.in_eop  = e;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge sys_clk);
      r = bus.in_rdy;
      @(posedge sys_clk);
      #1;
      if (r) done = 1;
      else if (count_stall) stalls++;
    end
    if (!done) begin
      compared++;
      mismatched++;
      $display("FAIL handshake_timeout: in_rdy stayed 0, expected 1");
    end
    bus.in_vld = 1'b0;
    bus.in_sop = 1'b0;
    bus.in_eop = 1'b0;
  endtask

  function automatic logic [15:0] word_of(input vec_t v, input int tag, input int i);
    if (i == 0) return {v.len, 3'b000, v.port};
    return 16'((tag << 8) | (i & 255));
  endfunction

  task automatic send_pkt(input vec_t v, input int tag);
    for (int i = 0; i < v.exp_emit; i++)
      sb.push_back('{data: word_of(v, tag, i), port: v.port, eop: (i == v.exp_emit - 1)});
    for (int i = 0; i < v.nwords; i++) begin
      if (v.gap_len > 0 && i == v.gap_at)
        for (int g = 0; g < v.gap_len; g++) begin
          @(posedge sys_clk);
          #1;
        end
      send_word(word_of(v, tag, i), (i == 0), (i == v.nwords - 1), (i >= 2));
    end
  endtask

  task automatic wait_idle();
    int quiet;
    quiet = 0;
    for (int k = 0; k < 500 && quiet < 4; k++) begin
      @(negedge sys_clk);
      if (!en_a && sb.size() == 0) quiet++;
      else quiet = 0;
    end
    if (quiet < 4) begin
      compared++;
      mismatched++;
      $display("FAIL idle_timeout: %0d writes outstanding, expected 0", sb.size());
    end
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_en_a"},     {31'd0, en_a},       32'd0);
    check({tag, "_wr_eop"},   {31'd0, wr_eop},     32'd0);
    check({tag, "_data_ina"}, {16'd0, data_ina},   32'd0);
    check({tag, "_port_ina"}, {28'd0, port_ina},   32'd0);
    check({tag, "_pkt_cnt"},  {16'd0, pkt_cnt},    32'd0);
    check({tag, "_drop_cnt"}, {16'd0, drop_cnt},   32'd0);
    check({tag, "_len_err"},  {31'd0, len_err},    32'd0);
    check({tag, "_in_rdy"},   {31'd0, bus.in_rdy}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1);
  end

  initial begin
    vec_t vt[13];
    vec_t v;
    int   e0;

    vt[0]  = '{len: 9'd17, port: 4'd3,  nwords: 17, cnt: 12'd100, gap_at: 0, gap_len: 0, exp_emit: 17, exp_drop: 0, exp_err: 0};
    vt[1]  = '{len: 9'd24, port: 4'd5,  nwords: 24, cnt: 12'd2,   gap_at: 0, gap_len: 0, exp_emit: 0,  exp_drop: 1, exp_err: 0};
    vt[2]  = '{len: 9'd5,  port: 4'd1,  nwords: 3,  cnt: 12'd100, gap_at: 0, gap_len: 0, exp_emit: 3,  exp_drop: 0, exp_err: 1};
    vt[3]  = '{len: 9'd4,  port: 4'd2,  nwords: 6,  cnt: 12'd100, gap_at: 0, gap_len: 0, exp_emit: 4,  exp_drop: 0, exp_err: 1};
    vt[4]  = '{len: 9'd8,  port: 4'd4,  nwords: 8,  cnt: 12'd1,   gap_at: 4, gap_len: 3, exp_emit: 8,  exp_drop: 0, exp_err: 0};
    vt[5]  = '{len: 9'd1,  port: 4'd6,  nwords: 1,  cnt: 12'd1,   gap_at: 0, gap_len: 0, exp_emit: 1,  exp_drop: 0, exp_err: 0};
    vt[6]  = '{len: 9'd3,  port: 4'd7,  nwords: 1,  cnt: 12'd100, gap_at: 0, gap_len: 0, exp_emit: 1,  exp_drop: 0, exp_err: 1};
    vt[7]  = '{len: 9'd0,  port: 4'd8,  nwords: 4,  cnt: 12'd100, gap_at: 0, gap_len: 0, exp_emit: 0,  exp_drop: 1, exp_err: 0};
    vt[8]  = '{len: 9'd16, port: 4'd9,  nwords: 16, cnt: 12'd2,   gap_at: 0, gap_len: 0, exp_emit: 16, exp_drop: 0, exp_err: 0};
    vt[9]  = '{len: 9'd17, port: 4'd10, nwords: 17, cnt: 12'd2,   gap_at: 0, gap_len: 0, exp_emit: 0,  exp_drop: 1, exp_err: 0};
    vt[10] = '{len: 9'd1,  port: 4'd11, nwords: 3,  cnt: 12'd100, gap_at: 0, gap_len: 0, exp_emit: 1,  exp_drop: 0, exp_err: 1};
    vt[11] = '{len: 9'd24, port: 4'd12, nwords: 1,  cnt: 12'd0,   gap_at: 0, gap_len: 0, exp_emit: 0,  exp_drop: 1, exp_err: 0};
    vt[12] = '{len: 9'd9,  port: 4'd13, nwords: 9,  cnt: 12'd2,   gap_at: 8, gap_len: 2, exp_emit: 9,  exp_drop: 0, exp_err: 0};

    bus.in_vld  = 1'b0;
    bus.in_sop  = 1'b0;
    bus.in_eop  = 1'b0;
    bus.in_data = '0;
    cnt_em      = 12'd100;

    // Reset state, then in_rdy rising on the first clock after release.
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk);
    check_reset_outputs("reset");
    @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk);
    check("in_rdy_after_release", {31'd0, bus.in_rdy}, 32'd1);
    @(posedge sys_clk);
    #1;

    // Table-driven packets, each run to quiescence before the next.
    for (int r = 0; r < 13; r++) begin
      cnt_em = vt[r].cnt;
      e0     = err_seen;
      stalls = 0;
      send_pkt(vt[r], r + 1);
      wait_idle();
      exp_pkt  += (vt[r].exp_emit > 0) ? 1 : 0;
      exp_drop += vt[r].exp_drop;
      check($sformatf("row%0d_pkt_cnt", r),  {16'd0, pkt_cnt},  32'(exp_pkt));
      check($sformatf("row%0d_drop_cnt", r), {16'd0, drop_cnt}, 32'(exp_drop));
      check($sformatf("row%0d_len_err", r),  32'(err_seen - e0), 32'(vt[r].exp_err));
      check($sformatf("row%0d_in_rdy_stalls", r), 32'(stalls), 32'd0);
    end

    // Two 8-word packets back-to-back, 3-cycle valid gap inside the first.
    cnt_em = 12'd100;
    runs.delete();
    v = '{len: 9'd8, port: 4'd14, nwords: 8, cnt: 12'd100, gap_at: 5, gap_len: 3, exp_emit: 8, exp_drop: 0, exp_err: 0};
    send_pkt(v, 40);
    v.port   = 4'd15;
    v.gap_len = 0;
    send_pkt(v, 41);
    wait_idle();
    exp_pkt += 2;
    check("b2b_pkt_cnt", {16'd0, pkt_cnt}, 32'(exp_pkt));
    check("b2b_burst_count", 32'(runs.size()), 32'd2);
    if (runs.size() == 2) begin
      check("b2b_burst0_len", 32'(runs[0]), 32'd8);
      check("b2b_burst1_len", 32'(runs[1]), 32'd8);
    end

    // Back-to-back packets whose headers arrive while earlier pages still drain.
    e0 = err_seen;
    v = '{len: 9'd9, port: 4'd2, nwords: 9, cnt: 12'd100, gap_at: 0, gap_len: 0, exp_emit: 9, exp_drop: 0, exp_err: 0};
    send_pkt(v, 50);
    v.port = 4'd6;
    send_pkt(v, 51);
    v = '{len: 9'd3, port: 4'd9, nwords: 3, cnt: 12'd100, gap_at: 0, gap_len: 0, exp_emit: 3, exp_drop: 0, exp_err: 0};
    send_pkt(v, 52);
    wait_idle();
    exp_pkt += 3;
    check("overlap_pkt_cnt", {16'd0, pkt_cnt}, 32'(exp_pkt));
    check("overlap_len_err", 32'(err_seen - e0), 32'd0);

    // Reset asserted while word 10 of a 20-word packet is offered.
    v = '{len: 9'd20, port: 4'd5, nwords: 20, cnt: 12'd100, gap_at: 0, gap_len: 0, exp_emit: 8, exp_drop: 0, exp_err: 0};
    for (int i = 0; i < 8; i++)
      sb.push_back('{data: word_of(v, 60, i), port: v.port, eop: 1'b0});
    for (int i = 0; i < 9; i++)
      send_word(word_of(v, 60, i), (i == 0), 1'b0, 1'b0);
    bus.in_vld  = 1'b1;
    bus.in_data = word_of(v, 60, 9);
    @(negedge sys_clk);
    sys_rst_n  = 1'b0;
    bus.in_vld = 1'b0;
    #1;
    check_reset_outputs("midpkt_reset");
    sb.delete();
    exp_pkt  = 0;
    exp_drop = 0;
    repeat (2) @(posedge sys_clk);
    #1 sys_rst_n = 1'b1;
    @(posedge sys_clk);
    #1;
    e0 = err_seen;
    v = '{len: 9'd10, port: 4'd6, nwords: 10, cnt: 12'd100, gap_at: 0, gap_len: 0, exp_emit: 10, exp_drop: 0, exp_err: 0};
    send_pkt(v, 61);
    wait_idle();
    check("post_reset_pkt_cnt",  {16'd0, pkt_cnt},  32'd1);
    check("post_reset_drop_cnt", {16'd0, drop_cnt}, 32'd0);
    check("post_reset_len_err",  32'(err_seen - e0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
